// File: rtl/range_window_ctrl.sv
// Window sequencer for a RangeFinder: frames sample windows with go/finish pulses,
// captures the resulting range and hands it out over a valid/ready interface.
module range_window_ctrl #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic [CNT_W-1:0] win_len,
    output logic             rf_go,
    output logic             rf_finish,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_error,
    output logic [WIDTH-1:0] result,
    output logic             result_err,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic [7:0]       overrun
);

    typedef enum logic [1:0] {StIdle, StRun, StCapture} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               cont_q, cont_d;
    logic               capture;
    logic               rf_go_q, rf_go_d;
    logic               rf_finish_q, rf_finish_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               result_err_q, result_err_d;
    logic               result_valid_q, result_valid_d;
    logic [7:0]         overrun_q, overrun_d;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= CNT_W'(1);
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            cont_q  <= cont_d;
        end
    end

    // Next-state logic; stop outranks start and suppresses capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        cont_d  = cont_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    len_d   = (win_len == '0) ? CNT_W'(1) : win_len;
                    cont_d  = cont;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (cnt_q == len_q - CNT_W'(1)) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCapture: begin
                if (stop) begin
                    state_d = StIdle;
                end else begin
                    capture = 1'b1;
                    if (cont_q) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: go/finish are precomputed from the upcoming state so they leave a flop
    always_comb begin
        rf_go_d     = (state_d == StRun) && (cnt_d == '0);
        rf_finish_d = (state_d == StRun) && (cnt_d == len_d - CNT_W'(1));
        busy        = (state_q != StIdle);
    end

    always_comb begin
        result_d       = result_q;
        result_err_d   = result_err_q;
        result_valid_d = result_valid_q;
        overrun_d      = overrun_q;
        if (capture) begin
            result_d       = rf_range;
            result_err_d   = rf_error;
            result_valid_d = 1'b1;
            if (result_valid_q && !result_ready && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end
        end else if (result_ready) begin
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_go_q        <= 1'b0;
            rf_finish_q    <= 1'b0;
            result_q       <= '0;
            result_err_q   <= 1'b0;
            result_valid_q <= 1'b0;
            overrun_q      <= '0;
        end else begin
            rf_go_q        <= rf_go_d;
            rf_finish_q    <= rf_finish_d;
            result_q       <= result_d;
            result_err_q   <= result_err_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign rf_go        = rf_go_q;
    assign rf_finish    = rf_finish_q;
    assign result       = result_q;
    assign result_err   = result_err_q;
    assign result_valid = result_valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_range_window_ctrl.sv
// Bench for range_window_ctrl: directed and random stimulus against a window-position
// model (position within the window derived arithmetically from the start cycle).
module tb_range_window_ctrl;

    localparam int WIDTH = 12;
    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             cont = 1'b0;
    logic [CNT_W-1:0] win_len = '0;
    logic             rf_go;
    logic             rf_finish;
    logic [WIDTH-1:0] rf_range = '0;
    logic             rf_error = 1'b0;
    logic [WIDTH-1:0] result;
    logic             result_err;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic             busy;
    logic [7:0]       overrun;

    range_window_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .cont         (cont),
        .win_len      (win_len),
        .rf_go        (rf_go),
        .rf_finish    (rf_finish),
        .rf_range     (rf_range),
        .rf_error     (rf_error),
        .result       (result),
        .result_err   (result_err),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // Reference model
    int cyc = 0;
    bit m_active = 0;
    int m_begin = 0;
    int m_n = 1;
    bit m_cont = 0;
    bit m_valid = 0;
    int m_res = 0;
    bit m_err = 0;
    int m_ovr = 0;
    int fixed_range = -1;
    int go_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int cur_p();
        int rel;
        rel = cyc - m_begin;
        return m_cont ? (rel % (m_n + 1)) : rel;
    endfunction

    task automatic check_outputs();
        int p;
        p = cur_p();
        chk("rf_go", 32'(rf_go), 32'(m_active && p == 0));
        chk("rf_finish", 32'(rf_finish), 32'(m_active && p == m_n - 1));
        chk("busy", 32'(busy), 32'(m_active));
        chk("result_valid", 32'(result_valid), 32'(m_valid));
        chk("result", 32'(result), 32'(m_res));
        chk("result_err", 32'(result_err), 32'(m_err));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (rf_go) go_seen++;
    endtask

    // At a negedge: check what the last edge produced, then drive the next edge's inputs.
    task automatic step(input bit st, input bit sp, input bit ct, input int wl, input bit rdy);
        bit cap;
        int p;
        check_outputs();
        start        = st;
        stop         = sp;
        cont         = ct;
        win_len      = CNT_W'(wl);
        result_ready = rdy;
        rf_range     = (fixed_range >= 0) ? WIDTH'(fixed_range) : WIDTH'($urandom);
        rf_error     = 1'($urandom);
        cap = 0;
        if (m_active) begin
            p = cur_p();
            if (sp) begin
                m_active = 0;
            end else if (p == m_n) begin
                cap = 1;
                if (!m_cont) m_active = 0;
            end
        end else if (st && !sp) begin
            m_active = 1;
            m_begin  = cyc + 1;
            m_n      = (wl == 0) ? 1 : wl;
            m_cont   = ct;
        end
        if (cap) begin
            if (m_valid && !rdy && m_ovr < 255) m_ovr++;
            m_valid = 1;
            m_res   = int'(rf_range);
            m_err   = rf_error;
        end else if (rdy) begin
            m_valid = 0;
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy);
    endtask

    task automatic reset_now();
        start = 0;
        stop = 0;
        result_ready = 0;
        reset_n = 0;
        #1;
        chk("rst_rf_go", 32'(rf_go), 0);
        chk("rst_rf_finish", 32'(rf_finish), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_result_err", 32'(result_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        m_active = 0;
        m_valid = 0;
        m_res = 0;
        m_err = 0;
        m_ovr = 0;
        @(negedge clock);
        reset_n = 1;
        cyc++;
    endtask

    initial begin
        int g0;
        @(negedge clock);
        reset_now();

        // Single window, length 4, fixed range
        fixed_range = 'h123;
        step(1, 0, 0, 4, 0);
        idle(6, 0);
        fixed_range = -1;
        chk("w4_result", 32'(result), 32'h123);
        chk("w4_valid", 32'(result_valid), 1);
        chk("w4_busy", 32'(busy), 0);
        idle(2, 1);

        // Zero and one-length windows collapse to one RUN cycle
        step(1, 0, 0, 0, 0);
        idle(4, 0);
        idle(1, 1);
        step(1, 0, 0, 1, 0);
        idle(4, 0);
        idle(1, 1);

        // Continuous, length 3, always ready, then stop
        g0 = go_seen;
        step(1, 0, 1, 3, 1);
        for (int i = 0; i < 24; i++) step(1'($urandom), 0, 1'($urandom), $urandom_range(0, 7), 1);
        step(0, 1, 0, 0, 1);
        idle(10, 1);
        chk("cont3_go_count", 32'(go_seen - g0), 32'd7);
        chk("cont3_overrun", 32'(overrun), 0);

        // Handshake in the capture cycle: load new, keep valid, no overrun
        step(1, 0, 1, 2, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, m_active && cur_p() == m_n);
        step(0, 1, 0, 0, 0);
        idle(3, 0);
        chk("hs_overrun", 32'(overrun), 0);
        chk("hs_valid", 32'(result_valid), 1);
        idle(1, 1);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, 1'($urandom),
                 $urandom_range(0, 6), 1'($urandom));
        step(0, 1, 0, 0, 1);
        idle(2, 1);

        // Overrun saturation over 300 continuous windows
        reset_now();
        step(1, 0, 1, 2, 0);
        for (int i = 0; i < 900; i++) step(0, 0, 0, 0, 0);
        chk("sat_overrun", 32'(overrun), 32'd255);
        step(0, 1, 0, 0, 0);
        idle(2, 0);
        chk("sat_result", 32'(result), 32'(m_res));
        idle(1, 1);

        // Reset during cycle 2 of a 5-cycle window
        step(1, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0);
        check_outputs();
        reset_now();
        g0 = go_seen;
        idle(10, 0);
        chk("post_rst_go", 32'(go_seen - g0), 0);
        chk("post_rst_valid", 32'(result_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/range_window_ctrl.md
RANGE_WINDOW_CTRL -- requirements
Module: range_window_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 12, sample/range width; CNT_W, default 8, window-length counter width.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset; one clock domain.
REQ-004 start  input  1  single-shot pulse; begins a window (or a continuous run) when idle.
REQ-005 stop  input  1  aborts the current window and any continuous run.
REQ-006 cont  input  1  continuous mode; sampled together with start.
REQ-007 win_len  input  CNT_W  samples per window; sampled together with start.
REQ-008 rf_go  output  1  drives RangeFinder go; high on the first sample of a window.
REQ-009 rf_finish  output  1  drives RangeFinder finish; high on the last sample of a window.
REQ-010 rf_range  input  WIDTH  RangeFinder range; valid the cycle after rf_finish.
REQ-011 rf_error  input  1  RangeFinder debug_error; valid the cycle after rf_finish.
REQ-012 result  output  WIDTH  captured range of the last completed window.
REQ-013 result_err  output  1  captured rf_error for that window.
REQ-014 result_valid / result_ready  output / input  1 / 1  valid-ready handshake on result.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 overrun  output  8  saturating count of results overwritten before being taken.

Function
REQ-017 FSM states SHALL be IDLE, RUN, CAPTURE.
REQ-018 IDLE: start=1 SHALL latch win_len (0 treated as 1) and cont, clear the sample counter, and enter RUN next cycle.
REQ-019 RUN: rf_go SHALL be high on RUN cycle 1 only; rf_finish high on RUN cycle N only; N=1 asserts both in the same cycle.
REQ-020 RUN SHALL last exactly N cycles, then enter CAPTURE.
REQ-021 CAPTURE (1 cycle) SHALL load rf_range into result and rf_error into result_err, and set result_valid from the next cycle.
REQ-022 After CAPTURE: cont latched=1 -> RUN (rf_go next cycle, window period N+1); cont=0 -> IDLE.
REQ-023 result_valid SHALL hold, with result stable, until a cycle with result_ready=1, then clear.
REQ-024 A capture while result_valid=1 and result_ready=0 SHALL overwrite result and increment overrun (saturate at 255).
REQ-025 Handshake and capture in the same cycle SHALL load the new result, keep result_valid=1, and not count an overrun.
REQ-026 stop=1 in RUN or CAPTURE SHALL enter IDLE next cycle, suppress capture, and deassert rf_go/rf_finish that cycle; stop has priority over start.
REQ-027 start in RUN or CAPTURE SHALL be ignored; win_len/cont changes mid-run have no effect until the next start.
REQ-028 rf_go, rf_finish SHALL be registered outputs, glitch-free.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE, rf_go=0, rf_finish=0, result=0, result_err=0, result_valid=0, busy=0, overrun=0.
REQ-030 Reset mid-window SHALL discard the window; no result is produced after release.

Verification
REQ-031 start, win_len=4, cont=0 -> rf_go cycle 1, rf_finish cycle 4; rf_range=0x123 captured; result_valid with result=0x123; then IDLE, busy=0.
REQ-032 win_len=0 and win_len=1 -> single RUN cycle with rf_go=rf_finish=1; one result.
REQ-033 cont=1, win_len=3, result_ready=1 -> rf_go every 4 cycles; each result taken; overrun=0; stop -> IDLE, no further rf_go.
REQ-034 cont=1, win_len=2, result_ready=0 for 300 windows -> overrun saturates at 255; result holds the latest rf_range.
REQ-035 result_ready pulsed in the capture cycle -> new result loaded, result_valid stays 1, overrun unchanged.
REQ-036 reset_n low during RUN (cycle 2 of 5) -> all outputs 0 immediately; no rf_finish or result after release.
